// File: rtl/dmem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared data memory.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    // requester side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wd0;
    logic [DATA_W-1:0] wd1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    // memory side
    logic              mem_WE;
    logic [ADDR_W-1:0] mem_Address;
    logic [DATA_W-1:0] mem_WD;
    logic [DATA_W-1:0] mem_RD;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1,
        output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
        output mem_WE, mem_Address, mem_WD,
        input  mem_RD
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
        input  mem_WE, mem_Address, mem_WD,
        output mem_RD
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded hold window in front of single-port data_mem.
module dmem_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH      = 100,
    parameter int unsigned MAX_HOLD   = 4,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;     // 1: port 1 owned most recently
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                done0_q, done1_q, err0_q, err1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;

    logic                xfer0, xfer1, in_range;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wd;

    assign xfer0 = (state_q == OWN0) && bus.req0;
    assign xfer1 = (state_q == OWN1) && bus.req1;

    // Route the transferring port to memory; everything idles at zero otherwise
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_wd   = '0;
        if (xfer0) begin
            sel_we   = bus.we0;
            sel_addr = bus.addr0;
            sel_wd   = bus.wd0;
        end else if (xfer1) begin
            sel_we   = bus.we1;
            sel_addr = bus.addr1;
            sel_wd   = bus.wd1;
        end
    end

    assign in_range        = sel_addr < DEPTH_A;
    assign bus.mem_WE      = sel_we & in_range;
    assign bus.mem_Address = sel_addr;
    assign bus.mem_WD      = sel_wd;

    // Ownership next-state: tie-break from IDLE, release on drop, forced handoff on full hold window
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (bus.req0 && bus.req1) begin
                    state_d = ((FIXED_PRIO != 0) || last_q) ? OWN0 : OWN1;
                end else if (bus.req0) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? OWN1 : IDLE;
                    last_d  = 1'b0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    if (bus.req1) begin
                        state_d = OWN1;
                        last_d  = 1'b0;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? OWN0 : IDLE;
                    last_d  = 1'b1;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    if (bus.req0) begin
                        state_d = OWN0;
                        last_d  = 1'b1;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // State, hold counter and per-transfer completion registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            hold_q   <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            done0_q <= xfer0;
            done1_q <= xfer1;
            err0_q  <= xfer0 && !in_range;
            err1_q  <= xfer1 && !in_range;
            if (xfer0) begin
                if (!in_range) begin
                    rdata0_q <= '0;
                end else if (!bus.we0) begin
                    rdata0_q <= bus.mem_RD;
                end
            end
            if (xfer1) begin
                if (!in_range) begin
                    rdata1_q <= '0;
                end else if (!bus.we1) begin
                    rdata1_q <= bus.mem_RD;
                end
            end
        end
    end

    assign bus.gnt0   = (state_q == OWN0);
    assign bus.gnt1   = (state_q == OWN1);
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.err0   = err0_q;
    assign bus.err1   = err1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_mem model.
module tb_dmem_arbiter;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 100;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) if_m ();
    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) if_fp ();

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MAX_HOLD(4), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .reset(reset), .bus(if_m.slave));

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MAX_HOLD(4), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset), .bus(if_fp.slave));

    always #5 clk = ~clk;

    // data_mem model: word i preloads to i*16+7, combinational read
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DW'(i * 16 + 7);
        end else if (if_m.mem_WE) begin
            mem[if_m.mem_Address] <= if_m.mem_WD;
        end
    end
    assign if_m.mem_RD  = (if_m.mem_Address < AW'(DEPTH)) ? mem[if_m.mem_Address] : '0;
    assign if_fp.mem_RD = '0;

    // {gnt0, gnt1, done0, done1, err0, err1}
    wire [5:0] flg_m  = {if_m.gnt0, if_m.gnt1, if_m.done0, if_m.done1, if_m.err0, if_m.err1};
    wire [5:0] flg_fp = {if_fp.gnt0, if_fp.gnt1, if_fp.done0, if_fp.done1, if_fp.err0, if_fp.err1};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_m.req0 = 0;  if_m.req1 = 0;  if_m.we0 = 0;  if_m.we1 = 0;
        if_m.addr0 = '0; if_m.addr1 = '0; if_m.wd0 = '0; if_m.wd1 = '0;
        if_fp.req0 = 0; if_fp.req1 = 0; if_fp.we0 = 0; if_fp.we1 = 0;
        if_fp.addr0 = '0; if_fp.addr1 = '0; if_fp.wd0 = '0; if_fp.wd1 = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        step(); step();
        n_total++; if (flg_m !== 6'b000000) $display("FAIL rst_flags: got %b expected %b", flg_m, 6'b000000); else n_pass++;
        n_total++; if ({if_m.rdata0, if_m.rdata1} !== 64'h0) $display("FAIL rst_rdata: got %h expected 0", {if_m.rdata0, if_m.rdata1}); else n_pass++;
        reset = 1;
        if_m.req0 = 1; if_m.we0 = 0; if_m.addr0 = 3;
        step();
        n_total++; if (flg_m !== 6'b100000) $display("FAIL rst_pre_gnt: got %b expected %b", flg_m, 6'b100000); else n_pass++;
        step();
        n_total++; if (flg_m !== 6'b101000) $display("FAIL rst_pre_done: got %b expected %b", flg_m, 6'b101000); else n_pass++;
        n_total++; if (if_m.rdata0 !== 32'h37) $display("FAIL rst_pre_rdata: got %h expected %h", if_m.rdata0, 32'h37); else n_pass++;
        if_m.we0 = 1; if_m.wd0 = 32'h99;
        #1;
        n_total++; if (if_m.mem_WE !== 1'b1) $display("FAIL rst_pre_we: got %b expected 1", if_m.mem_WE); else n_pass++;
        #1 reset = 0;
        #1;
        n_total++; if (flg_m !== 6'b000000) $display("FAIL rst_mid_flags: got %b expected %b", flg_m, 6'b000000); else n_pass++;
        n_total++; if (if_m.rdata0 !== 32'h0) $display("FAIL rst_mid_rdata: got %h expected 0", if_m.rdata0); else n_pass++;
        n_total++; if ({if_m.mem_WE, if_m.mem_Address} !== 33'h0) $display("FAIL rst_mid_mem: got %h expected 0", {if_m.mem_WE, if_m.mem_Address}); else n_pass++;
        step();
        reset = 1;
        if_m.req0 = 1; if_m.req1 = 1; if_m.we0 = 0; if_m.we1 = 0;
        step();
        n_total++; if (flg_m[5:4] !== 2'b10) $display("FAIL rst_first_tie: got %b expected %b", flg_m[5:4], 2'b10); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (flg_m !== 6'b000000) $display("FAIL rst_release_idle: got %b expected %b", flg_m, 6'b000000); else n_pass++;
    endtask

    task automatic test_single;
        if_m.req0 = 1; if_m.we0 = 1; if_m.addr0 = 5; if_m.wd0 = 32'hA5A5;
        step();
        n_total++; if (flg_m !== 6'b100000) $display("FAIL single_gnt: got %b expected %b", flg_m, 6'b100000); else n_pass++;
        n_total++; if ({if_m.mem_WE, if_m.mem_Address, if_m.mem_WD} !== {1'b1, 32'd5, 32'hA5A5})
            $display("FAIL single_wr_bus: got %h expected %h", {if_m.mem_WE, if_m.mem_Address, if_m.mem_WD}, {1'b1, 32'd5, 32'hA5A5}); else n_pass++;
        step();
        n_total++; if (flg_m !== 6'b101000) $display("FAIL single_wr_done: got %b expected %b", flg_m, 6'b101000); else n_pass++;
        if_m.we0 = 0;
        #1;
        n_total++; if ({if_m.mem_WE, if_m.mem_Address} !== {1'b0, 32'd5}) $display("FAIL single_rd_bus: got %h expected %h", {if_m.mem_WE, if_m.mem_Address}, {1'b0, 32'd5}); else n_pass++;
        step();
        n_total++; if (flg_m !== 6'b101000) $display("FAIL single_rd_done: got %b expected %b", flg_m, 6'b101000); else n_pass++;
        n_total++; if (if_m.rdata0 !== 32'hA5A5) $display("FAIL single_rdata: got %h expected %h", if_m.rdata0, 32'hA5A5); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (flg_m !== 6'b000000) $display("FAIL single_idle: got %b expected %b", flg_m, 6'b000000); else n_pass++;
        n_total++; if ({if_m.rdata0, if_m.rdata1} !== {32'hA5A5, 32'h0}) $display("FAIL single_hold: got %h expected %h", {if_m.rdata0, if_m.rdata1}, {32'hA5A5, 32'h0}); else n_pass++;
    endtask

    task automatic test_out_of_range;
        if_m.req1 = 1; if_m.we1 = 1; if_m.addr1 = 100; if_m.wd1 = 32'hDEADBEEF;
        step();
        n_total++; if (flg_m !== 6'b010000) $display("FAIL oor_gnt: got %b expected %b", flg_m, 6'b010000); else n_pass++;
        n_total++; if ({if_m.mem_WE, if_m.mem_Address} !== {1'b0, 32'd100}) $display("FAIL oor_we: got %h expected %h", {if_m.mem_WE, if_m.mem_Address}, {1'b0, 32'd100}); else n_pass++;
        step();
        n_total++; if (flg_m !== 6'b010101) $display("FAIL oor_err: got %b expected %b", flg_m, 6'b010101); else n_pass++;
        n_total++; if (if_m.rdata1 !== 32'h0) $display("FAIL oor_rdata: got %h expected 0", if_m.rdata1); else n_pass++;
        if_m.addr1 = 99; if_m.wd1 = 32'h1234;
        #1;
        n_total++; if (if_m.mem_WE !== 1'b1) $display("FAIL edge_we: got %b expected 1", if_m.mem_WE); else n_pass++;
        step();
        n_total++; if (flg_m !== 6'b010100) $display("FAIL edge_done: got %b expected %b", flg_m, 6'b010100); else n_pass++;
        if_m.we1 = 0;
        step();
        n_total++; if (if_m.rdata1 !== 32'h1234) $display("FAIL edge_rdata: got %h expected %h", if_m.rdata1, 32'h1234); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (flg_m !== 6'b000000) $display("FAIL oor_idle: got %b expected %b", flg_m, 6'b000000); else n_pass++;
    endtask

    task automatic test_contention;
        logic [5:0] exp;
        int own, prev;
        if_m.req0 = 1; if_m.req1 = 1; if_m.addr0 = 1; if_m.addr1 = 2;
        prev = -1;
        for (int k = 1; k <= 16; k++) begin
            step();
            own = ((k - 1) / 4) % 2;
            exp = (own == 0) ? 6'b100000 : 6'b010000;
            if (prev == 0) exp[3] = 1'b1;
            if (prev == 1) exp[2] = 1'b1;
            n_total++; if (flg_m !== exp) $display("FAIL contend_%0d: got %b expected %b", k, flg_m, exp); else n_pass++;
            prev = own;
        end
        n_total++; if ({if_m.rdata0, if_m.rdata1} !== {32'h17, 32'h27}) $display("FAIL contend_rdata: got %h expected %h", {if_m.rdata0, if_m.rdata1}, {32'h17, 32'h27}); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (flg_m !== 6'b000000) $display("FAIL contend_idle: got %b expected %b", flg_m, 6'b000000); else n_pass++;
    endtask

    task automatic test_early_release;
        logic [5:0] exp_tbl [1:8];
        exp_tbl = '{6'b100000, 6'b101000, 6'b101000, 6'b010000, 6'b010100, 6'b010100, 6'b010100, 6'b100100};
        if_m.req0 = 1; if_m.req1 = 1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_total++; if (flg_m !== exp_tbl[k]) $display("FAIL early_%0d: got %b expected %b", k, flg_m, exp_tbl[k]); else n_pass++;
            if (k == 3) if_m.req0 = 0;
            if (k == 4) if_m.req0 = 1;
        end
        idle_inputs();
        step();
        n_total++; if (flg_m !== 6'b000000) $display("FAIL early_idle: got %b expected %b", flg_m, 6'b000000); else n_pass++;
    endtask

    task automatic test_fixed_prio;
        if_m.req0 = 1; if_fp.req0 = 1;
        step();
        n_total++; if ({flg_m[5:4], flg_fp[5:4]} !== 4'b1010) $display("FAIL fp_solo: got %b expected %b", {flg_m[5:4], flg_fp[5:4]}, 4'b1010); else n_pass++;
        idle_inputs();
        step();
        if_m.req0 = 1; if_m.req1 = 1; if_fp.req0 = 1; if_fp.req1 = 1;
        step();
        n_total++; if (flg_fp !== 6'b100000) $display("FAIL fp_tie: got %b expected %b", flg_fp, 6'b100000); else n_pass++;
        n_total++; if (flg_m !== 6'b010000) $display("FAIL rr_tie: got %b expected %b", flg_m, 6'b010000); else n_pass++;
        idle_inputs();
        step();
        n_total++; if ({flg_m, flg_fp} !== 12'h0) $display("FAIL fp_idle: got %b expected 0", {flg_m, flg_fp}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_out_of_range();
        test_contention();
        test_early_release();
        test_fixed_prio();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
